// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the 3-row line buffer ahead of the 3x3 convolution.
// Gates raster pixels into the buffer, tracks position, and strobes complete windows.
module conv_window_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         px_valid,
    input  logic signed [DATA_WIDTH-1:0] px_data,
    output logic                         px_ready,
    input  logic                         dn_ready,
    output logic                         lb_clear,
    output logic                         lb_in_valid,
    output logic signed [DATA_WIDTH-1:0] lb_pixel,
    output logic                         win_valid,
    output logic [15:0]                  win_row,
    output logic [15:0]                  win_col,
    output logic                         busy,
    output logic                         frame_done
);

    localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    logic        abort_q, abort_d;
    logic        win_valid_q, win_valid_d;
    logic [15:0] win_row_q, win_row_d;
    logic [15:0] win_col_q, win_col_d;
    logic        beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            abort_q     <= 1'b0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            abort_q     <= abort_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        abort_d     = 1'b0;
        win_valid_d = 1'b0;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        px_ready    = 1'b0;
        beat        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                col_d   = '0;
                row_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                px_ready = dn_ready;
                beat     = px_valid & dn_ready;
                if (beat) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                    // Window is reported one cycle later to line up with the buffer's output register.
                    if (row_q >= 16'd2 && col_q >= 16'd2) begin
                        win_valid_d = 1'b1;
                        win_row_d   = row_q - 16'd2;
                        win_col_d   = col_q - 16'd2;
                    end
                    if (row_q == ROW_LAST && col_q == COL_LAST) state_d = FLUSH;
                end
            end
            FLUSH: begin
                col_d   = '0;
                row_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A simultaneous beat still reaches the buffer, but its window is dropped.
        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            col_d       = '0;
            row_d       = '0;
            abort_d     = 1'b1;
            win_valid_d = 1'b0;
            win_row_d   = win_row_q;
            win_col_d   = win_col_q;
        end
    end

    assign lb_clear    = (state_q == CLEAR) | abort_q;
    assign frame_done  = (state_q == FLUSH) | abort_q;
    assign busy        = (state_q == CLEAR) | (state_q == STREAM);
    assign lb_in_valid = beat;
    assign lb_pixel    = (state_q == STREAM) ? px_data : '0;
    assign win_valid   = win_valid_q;
    assign win_row     = win_row_q;
    assign win_col     = win_col_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl on a 5x4 frame: normal, stalled, gapped,
// aborted, restarted and reset-interrupted frames.
module tb_conv_window_ctrl;

    localparam int DW = 16;
    localparam int W  = 5;
    localparam int H  = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start, abort, px_valid, dn_ready;
    logic signed [DW-1:0] px_data;
    logic                 px_ready, lb_clear, lb_in_valid, win_valid, busy, frame_done;
    logic signed [DW-1:0] lb_pixel;
    logic [15:0]          win_row, win_col;

    int checks = 0;
    int errors = 0;
    int win_cnt = 0;
    int fd_cnt = 0;

    conv_window_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
        .dn_ready(dn_ready), .lb_clear(lb_clear), .lb_in_valid(lb_in_valid),
        .lb_pixel(lb_pixel), .win_valid(win_valid), .win_row(win_row),
        .win_col(win_col), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (win_valid) win_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit expwin(input int k);
        int r, c;
        r = (k - 1) / W;
        c = (k - 1) % W;
        return (r >= 2) && (c >= 2);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_px_ready"}, px_ready, 0);
        chk({tag, "_lb_clear"}, lb_clear, 0);
        chk({tag, "_lb_in_valid"}, lb_in_valid, 0);
        chk({tag, "_lb_pixel"}, lb_pixel, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_win_row"}, win_row, 0);
        chk({tag, "_win_col"}, win_col, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    // mode: 0 normal, 1 dn_ready toggling, 2 input gap, 3 abort, 4 start mid-frame, 5 reset mid-frame
    task automatic run_frame(input int mode);
        int k = 1;
        int cyc = 0;
        int gap = 3;
        int w0 = win_cnt;
        int f0 = fd_cnt;
        bit acc, dr, pv;
        dn_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_lb_clear", lb_clear, 1);
        chk("clear_busy", busy, 1);
        chk("clear_px_ready", px_ready, 0);
        tick();
        chk("stream_lb_clear", lb_clear, 0);
        while (k <= W * H && cyc < 200) begin
            pv = 1'b1;
            dr = 1'b1;
            if (mode == 1) dr = (cyc % 2) == 1;
            if (mode == 2 && k == 8 && gap > 0) begin
                pv = 1'b0;
                gap--;
            end
            start    = (mode == 4 && k == 6);
            px_valid = pv;
            dn_ready = dr;
            px_data  = 16'(k);
            if (mode == 3 && k == 13) begin
                abort    = 1'b1;
                px_valid = 1'b0;
                tick();
                abort = 1'b0;
                chk("abort_lb_clear", lb_clear, 1);
                chk("abort_frame_done", frame_done, 1);
                chk("abort_busy", busy, 0);
                chk("abort_win_valid", win_valid, 0);
                tick();
                chk("abort_lb_clear_off", lb_clear, 0);
                chk("abort_frame_done_off", frame_done, 0);
                chk("abort_win_cnt", win_cnt - w0, 0);
                break;
            end
            if (mode == 5 && k == 10) begin
                #2;
                reset = 1'b1;
                #1;
                check_all_zero("rst_mid");
                @(posedge clk);
                #1;
                reset    = 1'b0;
                px_valid = 1'b0;
                tick();
                chk("rst_no_done", fd_cnt - f0, 0);
                chk("rst_busy", busy, 0);
                break;
            end
            #1;
            acc = pv & dr;
            chk("px_ready", px_ready, dr);
            chk("lb_in_valid", lb_in_valid, acc);
            if (acc) chk("lb_pixel", lb_pixel, k);
            tick();
            start = 1'b0;
            if (acc && expwin(k)) begin
                chk("win_valid", win_valid, 1);
                chk("win_row", win_row, (k - 1) / W - 2);
                chk("win_col", win_col, (k - 1) % W - 2);
            end else begin
                chk("win_idle", win_valid, 0);
            end
            if (acc) begin
                chk("busy_stream", busy, (k == W * H) ? 0 : 1);
                k++;
            end
            cyc++;
        end
        px_valid = 1'b0;
        dn_ready = 1'b1;
        start    = 1'b0;
        if (mode <= 2 || mode == 4) begin
            chk("frame_len", k, W * H + 1);
            chk("done_pulse", frame_done, 1);
            chk("done_busy", busy, 0);
            chk("done_px_ready", px_ready, 0);
            tick();
            chk("done_off", frame_done, 0);
            chk("win_count", win_cnt - w0, (H - 2) * (W - 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        px_valid = 1'b0;
        dn_ready = 1'b1;
        px_data  = '0;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check_all_zero("idle");

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_clear", lb_clear, 0);
        chk("idle_abort_done", frame_done, 0);

        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(3);
        run_frame(0);
        run_frame(4);
        run_frame(5);
        run_frame(0);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle_clear", lb_clear, 1);
        chk("start_abort_idle_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_clear_done", frame_done, 1);
        chk("abort_in_clear_busy", busy, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Frame-level sequencer for the 3-row line buffer feeding the 3x3 convolution stage.
- Accepts a raster pixel stream with a valid/ready handshake and gates pixels into the line buffer one per accepted beat.
- Clears the buffer at frame start and tracks row/column position.
- Emits a window-valid strobe aligned with the buffer's registered column outputs; signals frame completion.

Parameters:
- DATA_WIDTH, 16, pixel width in bits (`DATA_WIDTH).
- IMG_WIDTH, 28, pixels per row (`IMG_WIDTH); legal range 3..65535.
- IMG_HEIGHT, 28, rows per frame; legal range 3..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle frame start request
- abort  in  1  one-cycle frame abort request
- px_valid  in  1  upstream pixel valid
- px_data  in  DATA_WIDTH  upstream pixel, signed
- px_ready  out  1  controller accepts pixel this cycle
- dn_ready  in  1  downstream conv stage can take a window this cycle
- lb_clear  out  1  drives line buffer reset
- lb_in_valid  out  1  drives line buffer in_valid
- lb_pixel  out  DATA_WIDTH  drives line buffer pixel_in
- win_valid  out  1  line buffer row*_px outputs form the right-hand column of a complete 3x3 window
- win_row  out  16  output row index of that window (0..IMG_HEIGHT-3)
- win_col  out  16  output column index of that window (0..IMG_WIDTH-3)
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse at end of frame or abort

Behaviour:
- Reset (async) drives:
  - outputs: all 0, including lb_clear=0;
  - state: IDLE;
  - counters: 0.
- FSM has four states: IDLE, CLEAR, STREAM, FLUSH.
- IDLE:
  - px_ready=0, busy=0.
  - start=1 moves to CLEAR.
  - abort in IDLE is ignored.
- CLEAR (exactly 1 cycle):
  - lb_clear=1, px_ready=0, busy=1.
  - Counters col=0, row=0.
  - Next state: STREAM.
- STREAM:
  - busy=1; px_ready = dn_ready (combinational).
  - An accepted beat is px_valid & px_ready.
  - lb_in_valid = accepted beat, combinational; lb_pixel = px_data passthrough.
  - On each accepted beat, col increments; at IMG_WIDTH-1, col wraps to 0 and row increments.
  - The beat with row=IMG_HEIGHT-1 and col=IMG_WIDTH-1 moves to FLUSH.
- FLUSH (1 cycle):
  - px_ready=0, frame_done=1 (registered pulse).
  - Next state: IDLE.
- Window strobe:
  - An accepted beat at (row>=2, col>=2) schedules a window.
  - Next cycle (matching line buffer 1-cycle output register): win_valid=1, win_row=row-2, win_col=col-2.
  - Otherwise win_valid=0; win_row/win_col hold their last values.
  - Windows per frame = (IMG_HEIGHT-2)*(IMG_WIDTH-2).
  - The last window's win_valid coincides with the FLUSH cycle.
- Stalls: px_valid=0 or dn_ready=0 inserts bubbles. Counters hold; no win_valid is produced on a bubble.
- start while busy: ignored.
- abort while busy (CLEAR/STREAM/FLUSH):
  - Next cycle: lb_clear=1 for 1 cycle, frame_done=1, win_valid=0, state IDLE, counters 0.
  - Abort takes priority over a simultaneous accepted beat; that beat is still accepted and passed to the line buffer, but no window is reported.
- start and abort in the same IDLE cycle: start wins.
- Reset mid-frame: immediate IDLE with all outputs 0. No frame_done pulse.
- Counters are 16-bit unsigned. Comparisons use IMG_WIDTH-1 and IMG_HEIGHT-1 as constants.

Test Plan:
- IMG_WIDTH=5, IMG_HEIGHT=4, start, 20 pixels 1..20 with px_valid=1, dn_ready=1:
  - lb_clear pulses 1 cycle after start; px_ready rises next cycle.
  - win_valid pulses 6 times with (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - frame_done pulses the cycle after pixel 20; busy falls with it.
- Same frame with dn_ready toggling every cycle:
  - px_ready mirrors dn_ready.
  - Still exactly 6 win_valid pulses, in the same order.
  - No win_valid occurs on a cycle following a non-accepted beat.
- Same frame with px_valid low for 3 cycles after pixel 7:
  - Counters hold during the gap.
  - Window (0,0) strobe appears one cycle after pixel 13 is accepted.
- abort after pixel 12:
  - Next cycle: lb_clear=1, frame_done=1, busy=0, no further win_valid.
  - A fresh start then yields a full 6-window frame.
- start asserted mid-frame (after pixel 5): ignored; frame completes with 6 windows.
- reset asserted asynchronously mid-STREAM (between clock edges):
  - All outputs 0 immediately; no frame_done.
  - After release, start runs a clean frame.
